// File: rtl/ym_write_sequencer.sv
// ----------------------------------------------------------------------------
// ym_write_sequencer
//
// Purpose:
//   Queues YM3812 register writes (register index + data) posted by the MCA
//   I/O decode. Each queued write is replayed to the chip in two phases:
//   first an address-port write (A0=0, D=register index), then a data-port
//   write (A0=1, D=data). The chip's recovery times after each phase are
//   enforced in ext_clock cycles. Because of this, the host can post writes
//   back-to-back and does not need long extended bus cycles.
//
// Ports:
//   ext_clock  in   system clock (14.318 MHz). All flops use the rising edge.
//   chreset_l  in   asynchronous active-low reset
//   req_valid  in   producer has a write to post
//   req_ready  out  queue not full. A write is accepted when
//                   req_valid & req_ready at a rising edge.
//   req_reg    in   YM register index [7:0]
//   req_data   in   YM register data  [7:0]
//   ym_cs_l    out  chip select, active low, registered
//   ym_wr_l    out  write strobe, active low, registered
//   ym_a0      out  port select: 0 = address, 1 = data; registered
//   ym_d       out  data bus [7:0], registered
//   busy       out  queue non-empty or a write is in progress
//   level      out  queue occupancy [$clog2(DEPTH):0]
// ----------------------------------------------------------------------------
module ym_write_sequencer #(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int ADDR_WAIT = 48,
    parameter int DATA_WAIT = 330,
    parameter int CNT_W     = 9
) (
    input  logic                     ext_clock,
    input  logic                     chreset_l,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [7:0]               req_reg,
    input  logic [7:0]               req_data,
    output logic                     ym_cs_l,
    output logic                     ym_wr_l,
    output logic                     ym_a0,
    output logic [7:0]               ym_d,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    // Counter reload values. Each state lasts N cycles: the counter loads
    // N-1 on entry, counts down, and the state advances on the cycle it
    // reads zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] AWAIT_LD = CNT_W'(ADDR_WAIT - 1);
    localparam logic [CNT_W-1:0] DWAIT_LD = CNT_W'(DATA_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_PULSE,
        A_WAIT,
        D_SETUP,
        D_PULSE,
        D_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    // Each entry holds {reg, data}. The head is read asynchronously. This
    // lets IDLE put the register index on the pins at the same edge it
    // pops the entry, so cs_l falls one edge after the push.
    logic [15:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  count_q, count_d;
    logic           push;
    logic           pop;
    logic [15:0]    head;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]     hold_data_q, hold_data_d;
    logic           cs_l_q, cs_l_d;
    logic           wr_l_q, wr_l_d;
    logic           a0_q, a0_d;
    logic [7:0]     d_q, d_d;

    assign req_ready = (count_q != FULL);
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Queue storage has no reset. The occupancy count alone decides what
    // is valid, so stale contents are never issued.
    always_ff @(posedge ext_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_reg, req_data};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Each output takes the value that
    // belongs to the state being entered, so pins change exactly on the
    // state boundary. Within a state, a0/d are held, which keeps them
    // stable while wr_l is low and on the edge where wr_l rises.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        cs_l_d      = cs_l_q;
        wr_l_d      = wr_l_q;
        a0_d        = a0_q;
        d_d         = d_q;

        if (state_q == IDLE) begin
            if (pop) begin
                state_d     = A_SETUP;
                cnt_d       = SETUP_LD;
                hold_data_d = head[7:0];
                cs_l_d      = 1'b0;
                wr_l_d      = 1'b1;
                a0_d        = 1'b0;
                d_d         = head[15:8];
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            case (state_q)
                A_SETUP: begin
                    state_d = A_PULSE;
                    cnt_d   = PULSE_LD;
                    wr_l_d  = 1'b0;
                end
                A_PULSE: begin
                    state_d = A_WAIT;
                    cnt_d   = AWAIT_LD;
                    cs_l_d  = 1'b1;
                    wr_l_d  = 1'b1;
                end
                A_WAIT: begin
                    state_d = D_SETUP;
                    cnt_d   = SETUP_LD;
                    cs_l_d  = 1'b0;
                    wr_l_d  = 1'b1;
                    a0_d    = 1'b1;
                    d_d     = hold_data_q;
                end
                D_SETUP: begin
                    state_d = D_PULSE;
                    cnt_d   = PULSE_LD;
                    wr_l_d  = 1'b0;
                end
                D_PULSE: begin
                    state_d = D_WAIT;
                    cnt_d   = DWAIT_LD;
                    cs_l_d  = 1'b1;
                    wr_l_d  = 1'b1;
                end
                D_WAIT: begin
                    // IDLE always lasts at least one cycle. This gives the
                    // fixed one-cycle gap before the next cs_l fall.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    cs_l_d  = 1'b1;
                    wr_l_d  = 1'b1;
                end
            endcase
        end
    end

    // Reset abandons any in-flight write. The queue is emptied by
    // clearing its pointers and count.
    always_ff @(posedge ext_clock or negedge chreset_l) begin
        if (!chreset_l) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_data_q <= 8'h00;
            cs_l_q      <= 1'b1;
            wr_l_q      <= 1'b1;
            a0_q        <= 1'b0;
            d_q         <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            cs_l_q      <= cs_l_d;
            wr_l_q      <= wr_l_d;
            a0_q        <= a0_d;
            d_q         <= d_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign ym_cs_l = cs_l_q;
    assign ym_wr_l = wr_l_q;
    assign ym_a0   = a0_q;
    assign ym_d    = d_q;
    assign busy    = (count_q != '0) || (state_q != IDLE);
    assign level   = count_q;

endmodule
